// File: rtl/riscv_pkg.sv
// Shared core types: memory-port return FSM encoding and arbiter defaults.
// No logic; imported by the arbiter and its priority sub-block.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } retStateT;

  localparam int STARVE_LIMIT_DEF = 4;

  // Counter width able to hold 0..limit inclusive.
  function automatic int cntWidth(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_prio2.sv
// Two-way fetch/data priority with fetch anti-starvation; grants are combinational, same cycle.
// No buffering: a denied requester must hold its request; grants are forced low during reset.
module arb_prio2
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ifReq,
  input  logic dmReq,
  output logic ifGnt,
  output logic dmGnt
);

  localparam int CW = cntWidth(STARVE_LIMIT);

  logic [CW-1:0] starveCnt;
  logic          starved;

  assign starved = (starveCnt == CW'(STARVE_LIMIT));

  always_comb begin
    ifGnt = 1'b0;
    dmGnt = 1'b0;
    if (!rst) begin
      if (ifReq && (!dmReq || starved)) begin
        ifGnt = 1'b1;
      end else if (dmReq) begin
        dmGnt = 1'b1;
      end
    end
  end

  // Counts consecutive denied fetch cycles; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (ifReq && !ifGnt) begin
      if (!starved) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end else begin
      starveCnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync RAM port between fetch and data; grant same cycle, read data 1 cycle later.
// Losing requester is stalled and must hold its request; one access per cycle, back-to-back.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic [31:0]         conflict_cnt
);

  retStateT retState;

  arb_prio2 #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uPrio (
    .clk  (clk),
    .rst  (reset),
    .ifReq(if_req),
    .dmReq(dm_req),
    .ifGnt(if_gnt),
    .dmGnt(dm_gnt)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_wstrb = dm_wstrb;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  // Return owner for the cycle after the grant; writes complete on dm_gnt and return nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retState <= IDLE;
    end else if (if_gnt) begin
      retState <= RD_IF;
    end else if (dm_gnt && !dm_we) begin
      retState <= RD_DM;
    end else begin
      retState <= IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (if_req && dm_req && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign if_rvalid = (retState == RD_IF);
  assign dm_rvalid = (retState == RD_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign stall_if  = if_req & ~if_gnt;
  assign stall_mem = dm_req & ~dm_gnt;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; STARVE_LIMIT, default 4, maximum consecutive denied fetch cycles.
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port if_req  input  1  fetch read request; if_addr  input  ADDR_W  fetch address.
REQ-005 Port if_gnt  output  1  fetch granted this cycle; if_rvalid  output  1  fetch read data valid; if_rdata  output  DATA_W  fetch data.
REQ-006 Port dm_req  input  1  data request; dm_we  input  1  write; dm_wstrb  input  DATA_W/8  byte strobes; dm_addr  input  ADDR_W; dm_wdata  input  DATA_W.
REQ-007 Port dm_gnt  output  1  data granted; dm_rvalid  output  1  data read valid; dm_rdata  output  DATA_W  read data.
REQ-008 Port mem_en  output  1; mem_we  output  1; mem_wstrb  output  DATA_W/8; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W -- the shared synchronous RAM port, with a fixed 1-cycle read latency.
REQ-009 Port stall_if  output  1  fetch stall to hazard unit; stall_mem  output  1  memory-stage stall to hazard unit.
REQ-010 Port conflict_cnt  output  32  saturating count of cycles in which both requesters are active.

Function
REQ-011 Grant SHALL be combinational in the request cycle; at most one of if_gnt and dm_gnt SHALL be high in any cycle.
REQ-012 Priority: dm wins a conflict unless starve_cnt == STARVE_LIMIT, in which case if wins.
REQ-013 A lone requester SHALL be granted in the same cycle it requests.
REQ-014 On a grant: mem_en=1, and mem_addr/mem_we/mem_wstrb/mem_wdata are taken from the winner (fetch: we=0, wstrb=0); with no grant: mem_en=0 and all mem_* outputs are 0.
REQ-015 starve_cnt: increments when if_req & !if_gnt, saturating at STARVE_LIMIT; clears to 0 on if_gnt or !if_req.
REQ-016 Return FSM states: IDLE, RD_IF, RD_DM. Next state is RD_IF after an if grant, RD_DM after a dm read grant, and IDLE otherwise (including after a dm write).
REQ-017 In state RD_IF: if_rvalid=1. In state RD_DM: dm_rvalid=1. Both are 0 in IDLE.
REQ-018 Read-data routing: if_rdata and dm_rdata SHALL both be driven by mem_rdata; contents are meaningful only while the matching rvalid is high.
REQ-019 Writes SHALL produce no rvalid; dm_gnt serves as the write completion.
REQ-020 A new grant SHALL be issuable in the same cycle as a return, giving back-to-back throughput of 1 access/cycle.
REQ-021 Stall outputs: stall_if = if_req & !if_gnt; stall_mem = dm_req & !dm_gnt.
REQ-022 Requester rule: request and payload are held stable until granted; the arbiter does not buffer requests.
REQ-023 conflict_cnt SHALL increment on cycles where if_req & dm_req, and hold at 0xFFFF_FFFF.

Reset
REQ-024 Asserting reset SHALL immediately force: state=IDLE, starve_cnt=0, conflict_cnt=0, if_rvalid=0, dm_rvalid=0.
REQ-025 While reset is high, if_gnt and dm_gnt SHALL be 0 and mem_en SHALL be 0.
REQ-026 A read in flight when reset asserts SHALL be dropped and SHALL NOT be returned after reset releases.
REQ-027 The first grant SHALL occur in the first clock edge cycle after reset deasserts.

Structure
REQ-028 The FSM state encoding (IDLE/RD_IF/RD_DM) and the STARVE_LIMIT default SHALL live in the shared riscv package.
REQ-029 The priority and starvation logic SHALL be one sub-module, arb_prio2, instantiated once; the FSM, mux and counters SHALL be in the top.

Verification
REQ-030 Fetch only: if_req=1, if_addr=0x100 -> if_gnt same cycle, mem_addr=0x100, if_rvalid next cycle with the RAM word.
REQ-031 Conflict: both requesting, dm read 0x2000 -> dm_gnt, stall_if=1, dm_rvalid next cycle, conflict_cnt+1.
REQ-032 Starvation: dm_req held 6 cycles with if_req held (STARVE_LIMIT=4) -> if_gnt in the 5th cycle and stall_mem=1 that cycle, dm regranted in the 6th.
REQ-033 Write: dm_we=1, wstrb=0x3, addr=0x40, wdata=0xDEADBEEF -> mem_we=1, wstrb=0x3, no dm_rvalid; a readback returns 0x????BEEF bytes updated.
REQ-034 Reset mid-read: reset asserted in the cycle after an if grant -> if_rvalid=0 immediately, state IDLE, counters 0.
REQ-035 Back-to-back alternating if/dm reads for 8 cycles -> 8 returns, each rvalid matched to its owner, no gaps.
